// File: rtl/flash_bus_responder_pkg.sv
// Shared definitions for the manager/flash handshake: flow codes, FSM state
// encoding and default flash timing (cycles of CLK_50MHZ).
package flash_bus_responder_pkg;

    localparam logic FLOW_READ  = 1'b0;
    localparam logic FLOW_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } fb_state_e;

    localparam int DEF_T_SETUP = 1;
    localparam int DEF_T_RD    = 5;
    localparam int DEF_T_WR    = 4;
    localparam int DEF_T_HOLD  = 1;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/flash_bus_responder_if.sv
// Manager-facing request/completion bundle of the flash responder.
interface flash_bus_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    import flash_bus_responder_pkg::*;

    // fb_start requests an access and is honoured only while the responder is
    // idle (fb_busy low); flow/addr/wdata are taken on that same edge. Every
    // accepted request ends with exactly one fb_done pulse; fl_rdata is valid
    // from that pulse until the next read completes.
    logic              fb_start;
    logic              fl_flow;
    logic [ADDR_W-1:0] fl_addr;
    logic [DATA_W-1:0] fl_wdata;
    logic [DATA_W-1:0] fl_rdata;
    logic              fb_done;
    logic              fb_busy;
    fb_state_e         state;

    modport master (
        output fb_start, fl_flow, fl_addr, fl_wdata,
        input  fl_rdata, fb_done, fb_busy, state
    );

    modport slave (
        input  fb_start, fl_flow, fl_addr, fl_wdata,
        output fl_rdata, fb_done, fb_busy, state
    );

endinterface

// File: rtl/flash_phase_timer.sv
// Loadable down-counter that times each flash phase; zero marks the last
// cycle of the current phase.
module flash_phase_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/flash_bus_responder.sv
// Runs one timed CE#/OE#/WE# access on an asynchronous parallel flash per
// manager request and returns the read byte with a one-cycle fb_done.
module flash_bus_responder
    import flash_bus_responder_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int T_SETUP = DEF_T_SETUP,
    parameter int T_RD    = DEF_T_RD,
    parameter int T_WR    = DEF_T_WR,
    parameter int T_HOLD  = DEF_T_HOLD
) (
    input  logic                  CLK_50MHZ,
    input  logic                  RST,
    flash_bus_responder_if.slave  bus,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_dq_o,
    output logic                  mem_dq_oe,
    input  logic [DATA_W-1:0]     mem_dq_i,
    output logic                  mem_ce_n,
    output logic                  mem_oe_n,
    output logic                  mem_we_n
);

    localparam int CNT_W = $clog2(max4(T_SETUP, T_RD, T_WR, T_HOLD) + 1);
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_RD    = CNT_W'(T_RD - 1);
    localparam logic [CNT_W-1:0] LD_WR    = CNT_W'(T_WR - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);

    fb_state_e         state, state_next;
    logic              accept;
    logic              ld;
    logic [CNT_W-1:0]  ld_val;
    logic              t_zero;

    logic              flow_q, flow_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;
    logic [DATA_W-1:0] rdata_q;
    logic              done_q, busy_q;
    logic              active_n;

    flash_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (CLK_50MHZ),
        .rst      (RST),
        .load     (ld),
        .load_val (ld_val),
        .zero     (t_zero)
    );

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        ld         = 1'b0;
        ld_val     = '0;
        unique case (state)
            ST_IDLE: begin
                if (bus.fb_start) begin
                    accept     = 1'b1;
                    state_next = ST_SETUP;
                    ld         = 1'b1;
                    ld_val     = LD_SETUP;
                end
            end
            ST_SETUP: begin
                if (t_zero) begin
                    state_next = ST_STROBE;
                    ld         = 1'b1;
                    ld_val     = (flow_q == FLOW_WRITE) ? LD_WR : LD_RD;
                end
            end
            ST_STROBE: begin
                if (t_zero) begin
                    state_next = ST_HOLD;
                    ld         = 1'b1;
                    ld_val     = LD_HOLD;
                end
            end
            ST_HOLD: begin
                if (t_zero) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Pin registers are loaded from the next-cycle view so every flash strobe
    // changes on a clock edge together with the state it belongs to.
    assign flow_n   = accept ? bus.fl_flow  : flow_q;
    assign addr_n   = accept ? bus.fl_addr  : addr_q;
    assign wdata_n  = accept ? bus.fl_wdata : wdata_q;
    assign active_n = (state_next == ST_SETUP) || (state_next == ST_STROBE) ||
                      (state_next == ST_HOLD);

    always_ff @(posedge CLK_50MHZ or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            flow_q    <= FLOW_READ;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            mem_addr  <= '0;
            mem_dq_o  <= '0;
            mem_dq_oe <= 1'b0;
            mem_ce_n  <= 1'b1;
            mem_oe_n  <= 1'b1;
            mem_we_n  <= 1'b1;
        end else begin
            state <= state_next;
            if (accept) begin
                flow_q  <= bus.fl_flow;
                addr_q  <= bus.fl_addr;
                wdata_q <= bus.fl_wdata;
            end
            done_q    <= (state_next == ST_DONE);
            busy_q    <= (state_next != ST_IDLE);
            mem_ce_n  <= !active_n;
            mem_oe_n  <= !((state_next == ST_STROBE) && (flow_n == FLOW_READ));
            mem_we_n  <= !((state_next == ST_STROBE) && (flow_n == FLOW_WRITE));
            mem_dq_oe <= active_n && (flow_n == FLOW_WRITE);
            if (active_n) mem_addr <= addr_n;
            if (active_n && (flow_n == FLOW_WRITE)) mem_dq_o <= wdata_n;
            if ((state == ST_STROBE) && t_zero && (flow_q == FLOW_READ)) begin
                rdata_q <= mem_dq_i;
            end
        end
    end

    assign bus.fl_rdata = rdata_q;
    assign bus.fb_done  = done_q;
    assign bus.fb_busy  = busy_q;
    assign bus.state    = state;

endmodule
